// File: rtl/fifo_multichannel_accum.sv
// fifo_multichannel_accum: FIFOS_CNT independent FWFT FIFOs with in-place rotate-accumulate.
// Ports: clk, rst_all (sync, active-high, all channels), i_rst_channels (per-channel sync reset),
// write (i_wr_valid/i_wr_data), pop (i_rd_en), rotate-accumulate (i_acc_en/i_acc_data),
// head (o_rd_valid/o_rd_data), status flags, fill count, and one-cycle overflow/underflow/error pulses.
module fifo_multichannel_accum #(
  parameter int RAM_WIDTH          = 32,
  parameter int RAM_DEPTH          = 128,
  parameter int FIFOS_CNT          = 50,
  parameter int ACC_SATURATE       = 0,
  parameter int ALMOST_FULL_THRESH = RAM_DEPTH - 4
) (
  input  logic                                              clk,
  input  logic                                              rst_all,
  input  logic [FIFOS_CNT-1:0]                              i_rst_channels,
  input  logic [FIFOS_CNT-1:0]                              i_wr_valid_channels,
  input  logic [FIFOS_CNT*RAM_WIDTH-1:0]                    i_wr_data_channels,
  input  logic [FIFOS_CNT-1:0]                              i_rd_en_channels,
  input  logic [FIFOS_CNT-1:0]                              i_acc_en_channels,
  input  logic [FIFOS_CNT*RAM_WIDTH-1:0]                    i_acc_data_channels,
  output logic [FIFOS_CNT-1:0]                              o_rd_valid_channels,
  output logic [FIFOS_CNT*RAM_WIDTH-1:0]                    o_rd_data_channels,
  output logic [FIFOS_CNT-1:0]                              o_ready_channels,
  output logic [FIFOS_CNT-1:0]                              o_empty_channels,
  output logic [FIFOS_CNT-1:0]                              o_empty_next_channels,
  output logic [FIFOS_CNT-1:0]                              o_full_channels,
  output logic [FIFOS_CNT-1:0]                              o_full_next_channels,
  output logic [FIFOS_CNT-1:0]                              o_almost_full_channels,
  output logic [FIFOS_CNT*($clog2(RAM_DEPTH)+1)-1:0]        o_fill_count_channels,
  output logic [FIFOS_CNT-1:0]                              o_overflow_channels,
  output logic [FIFOS_CNT-1:0]                              o_underflow_channels,
  output logic [FIFOS_CNT-1:0]                              o_err_channels
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = AW + 1;
  for (genvar c = 0; c < FIFOS_CNT; c++) begin : g_ch
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic [RAM_WIDTH-1:0] head, wd, ad, acc_res;
    logic [RAM_WIDTH:0]   sum;
    logic                 rst_c, empty, full, wr_v, rd_v, acc_v;
    logic                 wr_ok, rd_ok, acc_ok, ovf, udf, err;
    assign rst_c = rst_all | i_rst_channels[c];
    assign wr_v  = i_wr_valid_channels[c];
    assign rd_v  = i_rd_en_channels[c];
    assign acc_v = i_acc_en_channels[c];
    assign wd    = i_wr_data_channels[c*RAM_WIDTH +: RAM_WIDTH];
    assign ad    = i_acc_data_channels[c*RAM_WIDTH +: RAM_WIDTH];
    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(RAM_DEPTH);
    // An accumulate request owns the channel for the cycle; wr/rd alongside it are ignored.
    assign acc_ok = acc_v && !empty;
    assign rd_ok  = !acc_v && rd_v && !empty;
    assign wr_ok  = !acc_v && wr_v && (!full || rd_v);
    always_comb begin
      sum     = {1'b0, head} + {1'b0, ad};
      acc_res = (ACC_SATURATE != 0 && sum[RAM_WIDTH]) ? '1 : sum[RAM_WIDTH-1:0];
    end
    // At full, wr_ptr == rd_ptr: the head is read combinationally before the edge overwrites it.
    always_ff @(posedge clk)
      if (!rst_c && (wr_ok || acc_ok)) mem[wr_ptr] <= acc_ok ? acc_res : wd;
    always_ff @(posedge clk) begin
      if (rst_c) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
        err    <= 1'b0;
      end else begin
        if (wr_ok || acc_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok || acc_ok) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(wr_ok) - CW'(rd_ok);
        ovf   <= !acc_v && wr_v && full && !rd_v;
        udf   <= !acc_v && rd_v && empty;
        err   <= acc_v && (empty || wr_v || rd_v);
      end
    end
    assign o_rd_valid_channels[c]                      = !empty;
    assign o_rd_data_channels[c*RAM_WIDTH +: RAM_WIDTH] = empty ? '0 : head;
    assign o_ready_channels[c]                         = !full;
    assign o_empty_channels[c]                         = empty;
    assign o_empty_next_channels[c]                    = count <= CW'(1);
    assign o_full_channels[c]                          = full;
    assign o_full_next_channels[c]                     = count >= CW'(RAM_DEPTH - 1);
    assign o_almost_full_channels[c]                   = count >= CW'(ALMOST_FULL_THRESH);
    assign o_fill_count_channels[c*CW +: CW]           = count;
    assign o_overflow_channels[c]                      = ovf;
    assign o_underflow_channels[c]                     = udf;
    assign o_err_channels[c]                           = err;
  end
endmodule

// File: tb/tb_fifo_multichannel_accum.sv
// tb_fifo_multichannel_accum: directed + random stimulus checked against a queue-based reference model.
module tb_fifo_multichannel_accum;
  localparam int N  = 50;
  localparam int W  = 32;
  localparam int D  = 128;
  localparam int CW = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic           rst_all;
  logic [N-1:0]   rstc, wr, rd, acc;
  logic [N*W-1:0] wd, ad;
  logic [N-1:0]   rv, rdy, emp, empn, ful, fuln, af, ovf, udf, err;
  logic [N*W-1:0] rdata;
  logic [N*CW-1:0] cnt;
  logic [1:0]     s_rstc, s_wr, s_rd, s_acc;
  logic [2*W-1:0] s_wd, s_ad, s_rdata;
  logic [1:0]     s_rv, s_rdy, s_emp, s_empn, s_ful, s_fuln, s_af, s_ovf, s_udf, s_err;
  logic [2*3-1:0] s_cnt;
  fifo_multichannel_accum #(.RAM_WIDTH(W), .RAM_DEPTH(D), .FIFOS_CNT(N)) dut (
    .clk(clk), .rst_all(rst_all), .i_rst_channels(rstc), .i_wr_valid_channels(wr),
    .i_wr_data_channels(wd), .i_rd_en_channels(rd), .i_acc_en_channels(acc),
    .i_acc_data_channels(ad), .o_rd_valid_channels(rv), .o_rd_data_channels(rdata),
    .o_ready_channels(rdy), .o_empty_channels(emp), .o_empty_next_channels(empn),
    .o_full_channels(ful), .o_full_next_channels(fuln), .o_almost_full_channels(af),
    .o_fill_count_channels(cnt), .o_overflow_channels(ovf), .o_underflow_channels(udf),
    .o_err_channels(err));
  fifo_multichannel_accum #(.RAM_WIDTH(W), .RAM_DEPTH(4), .FIFOS_CNT(2), .ACC_SATURATE(1),
    .ALMOST_FULL_THRESH(3)) dut_sat (
    .clk(clk), .rst_all(rst_all), .i_rst_channels(s_rstc), .i_wr_valid_channels(s_wr),
    .i_wr_data_channels(s_wd), .i_rd_en_channels(s_rd), .i_acc_en_channels(s_acc),
    .i_acc_data_channels(s_ad), .o_rd_valid_channels(s_rv), .o_rd_data_channels(s_rdata),
    .o_ready_channels(s_rdy), .o_empty_channels(s_emp), .o_empty_next_channels(s_empn),
    .o_full_channels(s_ful), .o_full_next_channels(s_fuln), .o_almost_full_channels(s_af),
    .o_fill_count_channels(s_cnt), .o_overflow_channels(s_ovf), .o_underflow_channels(s_udf),
    .o_err_channels(s_err));
  logic [W-1:0] q [N][$];
  logic [N-1:0] e_ovf, e_udf, e_err;
  int ncmp = 0, nfail = 0;
  task automatic cmp(input string tag, input int c, input logic [W-1:0] got, input logic [W-1:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s ch%0d observed %h expected %h", tag, c, got, exp);
    end
  endtask
  task automatic clear_in();
    rst_all = 0; rstc = '0; wr = '0; rd = '0; acc = '0; wd = '0; ad = '0;
    s_rstc = '0; s_wr = '0; s_rd = '0; s_acc = '0; s_wd = '0; s_ad = '0;
  endtask
  task automatic check();
    for (int c = 0; c < N; c++) begin
      int sz = q[c].size();
      cmp("count", c, W'(cnt[c*CW +: CW]), W'(sz));
      cmp("rd_valid", c, W'(rv[c]), W'(sz > 0));
      cmp("rd_data", c, rdata[c*W +: W], sz > 0 ? q[c][0] : '0);
      cmp("empty", c, W'(emp[c]), W'(sz == 0));
      cmp("empty_next", c, W'(empn[c]), W'(sz <= 1));
      cmp("full", c, W'(ful[c]), W'(sz == D));
      cmp("full_next", c, W'(fuln[c]), W'(sz >= D - 1));
      cmp("almost_full", c, W'(af[c]), W'(sz >= D - 4));
      cmp("ready", c, W'(rdy[c]), W'(sz != D));
      cmp("overflow", c, W'(ovf[c]), W'(e_ovf[c]));
      cmp("underflow", c, W'(udf[c]), W'(e_udf[c]));
      cmp("err", c, W'(err[c]), W'(e_err[c]));
    end
  endtask
  // Model: each channel is a queue; accumulate is pop-front then push-back of the wrapped sum.
  task automatic tick();
    for (int c = 0; c < N; c++) begin
      int sz = q[c].size();
      logic [W-1:0] h;
      e_ovf[c] = 0; e_udf[c] = 0; e_err[c] = 0;
      if (rst_all || rstc[c]) q[c].delete();
      else if (acc[c]) begin
        e_err[c] = sz == 0 || wr[c] || rd[c];
        if (sz > 0) begin
          h = q[c].pop_front();
          q[c].push_back(W'((64'(h) + 64'(ad[c*W +: W])) % (64'd1 << W)));
        end
      end else begin
        e_udf[c] = rd[c] && sz == 0;
        e_ovf[c] = wr[c] && sz == D && !rd[c];
        if (rd[c] && sz > 0) void'(q[c].pop_front());
        if (wr[c] && (sz < D || rd[c])) q[c].push_back(wd[c*W +: W]);
      end
    end
    @(posedge clk);
    #1;
    check();
  endtask
  initial begin
    clear_in();
    rst_all = 1;
    tick();
    clear_in();
    for (int i = 1; i <= 129; i++) begin
      wr[0] = 1; wd[0*W +: W] = W'(i);
      tick();
    end
    clear_in();
    tick();
    cmp("ch0_count_full", 0, W'(cnt[0 +: CW]), 32'd128);
    for (int i = 1; i <= 128; i++) begin
      acc[0] = 1; ad[0*W +: W] = W'(i);
      tick();
    end
    clear_in();
    cmp("acc_count", 0, W'(cnt[0 +: CW]), 32'd128);
    for (int i = 1; i <= 128; i++) begin
      cmp("acc_drain", 0, rdata[0 +: W], W'(2 * i));
      rd[0] = 1;
      tick();
    end
    clear_in();
    for (int i = 1; i <= 64; i++) begin
      wr[3] = 1; wd[3*W +: W] = W'(i);
      wr[4] = 1; wd[4*W +: W] = W'(1000 + i);
      tick();
    end
    rstc[3] = 1; wr[3] = 1; wd[4*W +: W] = 32'd2000;
    tick();
    clear_in();
    cmp("ch3_reset_rd_data", 3, rdata[3*W +: W], 32'd0);
    cmp("ch4_count", 4, W'(cnt[4*CW +: CW]), 32'd65);
    for (int i = 1; i <= 128; i++) begin
      wr[5] = 1; wd[5*W +: W] = W'(i);
      tick();
    end
    for (int i = 1; i <= 10; i++) begin
      cmp("ch5_order", 5, rdata[5*W +: W], W'(i));
      rd[5] = 1; wr[5] = 1; wd[5*W +: W] = W'(128 + i);
      tick();
    end
    clear_in();
    cmp("ch5_next", 5, rdata[5*W +: W], 32'd11);
    cmp("ch5_count", 5, W'(cnt[5*CW +: CW]), 32'd128);
    acc[6] = 1;
    tick();
    clear_in();
    cmp("ch6_err", 6, W'(err[6]), 32'd1);
    rd[6] = 1;
    tick();
    clear_in();
    cmp("ch6_underflow", 6, W'(udf[6]), 32'd1);
    wr[6] = 1; wd[6*W +: W] = 32'hA5;
    tick();
    clear_in();
    cmp("ch6_fwft", 6, rdata[6*W +: W], 32'hA5);
    wr[7] = 1; wd[7*W +: W] = 32'hFFFF_FFF0;
    s_wr[0] = 1; s_wd[0 +: W] = 32'hFFFF_FFF0;
    tick();
    clear_in();
    acc[7] = 1; ad[7*W +: W] = 32'h20;
    s_acc[0] = 1; s_ad[0 +: W] = 32'h20;
    tick();
    clear_in();
    cmp("wrap_acc", 7, rdata[7*W +: W], 32'h0000_0010);
    cmp("sat_acc", 0, s_rdata[0 +: W], 32'hFFFF_FFFF);
    cmp("sat_count", 0, W'(s_cnt[0 +: 3]), 32'd1);
    for (int t = 0; t < 600; t++) begin
      for (int c = 8; c < 16; c++) begin
        wr[c] = $urandom_range(0, 99) < 60;
        rd[c] = $urandom_range(0, 99) < 30;
        acc[c] = $urandom_range(0, 99) < 12;
        rstc[c] = $urandom_range(0, 299) == 0;
        wd[c*W +: W] = $urandom;
        ad[c*W +: W] = $urandom;
      end
      tick();
    end
    clear_in();
    for (int t = 0; t < 3; t++) begin
      acc[5] = 1; ad[5*W +: W] = W'(t + 1);
      tick();
    end
    rst_all = 1;
    for (int c = 0; c < 16; c++) acc[c] = 1;
    tick();
    clear_in();
    cmp("rst_all_ch5", 5, W'(cnt[5*CW +: CW]), 32'd0);
    cmp("rst_all_sat", 0, W'(s_emp[0]), 32'd1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
